// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline front end: fetch FSM encoding and the
// IF/ID pipeline register layout.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } ifid_t;

    // A bubble keeps the PC fields so downstream debug still sees the last address.
    function automatic ifid_t ifid_bubble(input ifid_t cur);
        ifid_t b;
        b       = cur;
        b.valid = 1'b0;
        b.instr = NOP_INSTR;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; resolves kill / load / flush / stall in that
// priority order, with reset above all of them.
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  ifid_t load_data,
    input  logic  kill,
    input  logic  flush,
    input  logic  stall,
    output ifid_t ifid
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (kill) begin
            ifid_d = ifid_bubble(ifid_q);
        end else if (load) begin
            ifid_d = load_data;
        end else if (flush || !stall) begin
            // flush wins over stall; with neither, the slot empties
            ifid_d = ifid_bubble(ifid_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory request
// in flight, buffers a response that lands during a stall, and feeds IF/ID.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    output logic         ifid_valid,
    output logic [31:0]  ifid_pc,
    output logic [31:0]  ifid_pc_plus4,
    output logic [31:0]  ifid_instr,
    output fetch_state_t dbg_state
);

    // Request handshake: a request transfers on a cycle where imem_req_valid
    // and imem_req_ready are both high. While valid waits for ready the
    // address is held, except that a redirect retargets it. Responses are
    // only accepted in WAIT/DROP; anything returned in IDLE or REQ is ignored.

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  hold_q, hold_d;
    logic         load;
    logic         kill;
    ifid_t        load_data;
    ifid_t        ifid;
    logic         handshake;

    assign handshake = (state_q == REQ) && imem_req_ready;

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        fetch_pc_d         = fetch_pc_q;
        hold_d             = hold_q;
        load               = 1'b0;
        kill               = 1'b0;
        load_data.valid    = 1'b1;
        load_data.pc       = fetch_pc_q;
        load_data.pc_plus4 = fetch_pc_q + 32'd4;
        load_data.instr    = imem_resp_data;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (handshake) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (!stall) begin
                        load    = 1'b1;
                        state_d = REQ;
                    end else begin
                        hold_d  = imem_resp_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    load            = 1'b1;
                    load_data.instr = hold_q;
                    state_d         = REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // A redirect overrides everything; an in-flight request whose response
        // is still to come must be swallowed in DROP.
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            load   = 1'b0;
            kill   = 1'b1;
            hold_d = NOP_INSTR;
            case (state_q)
                REQ:     state_d = handshake ? DROP : REQ;
                WAIT:    state_d = imem_resp_valid ? REQ : DROP;
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            hold_q     <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            hold_q     <= hold_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .kill      (kill),
        .flush     (flush),
        .stall     (stall),
        .ifid      (ifid)
    );

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc_q;
    assign ifid_valid     = ifid.valid;
    assign ifid_pc        = ifid.pc;
    assign ifid_pc_plus4  = ifid.pc_plus4;
    assign ifid_instr     = ifid.instr;
    assign dbg_state      = state_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and loads the IF/ID pipeline register. It consumes the hazard unit's `stall`/`flush` and the EX-stage redirect (taken branch/jump). It feeds the ID stage and the hazard unit's `ifid_rs`/`ifid_rt` inputs through `ifid_instr`.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard unit: hold PC and IF/ID contents
- `flush`  in  1  hazard unit: turn IF/ID into a bubble
- `redirect_valid`  in  1  EX stage: control transfer taken
- `redirect_pc`  in  32  target address, word-aligned
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  fetch address
- `imem_resp_valid`  in  1  instruction word returned, ≥1 cycle after acceptance
- `imem_resp_data`  in  32  instruction word
- `ifid_valid`  out  1  IF/ID holds a real instruction
- `ifid_pc`  out  32  PC of the IF/ID instruction
- `ifid_pc_plus4`  out  32  `ifid_pc + 4`
- `ifid_instr`  out  32  instruction; NOP (32'h0) when not valid

## Operation
- `pc_q` holds the next fetch address. `fetch_pc_q` holds the address of the outstanding request. At most one request is outstanding.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP. Reset state is IDLE.
- IDLE → REQ unconditionally.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=`pc_q`. On `valid & ready`: `fetch_pc_q`←`pc_q`, `pc_q`←`pc_q+4` (mod 2^32), go to WAIT.
- WAIT, on response:
  - if `!stall`, load IF/ID {1, `fetch_pc_q`, data} and go to REQ.
  - if `stall`, latch the data into the hold buffer and go to HOLD.
- HOLD: on the first cycle with `!stall`, load IF/ID from the hold buffer and go to REQ.
- DROP: discard the next response and go to REQ. No IF/ID load.
- Redirect has the highest priority in every state. It sets `pc_q`←`redirect_pc`, clears `ifid_valid`, and empties the hold buffer. Next state by current state:
  - REQ with a handshake in the same cycle → DROP.
  - REQ without a handshake → REQ.
  - WAIT with `imem_resp_valid` in the same cycle → REQ (response discarded).
  - WAIT without a response → DROP.
  - HOLD → REQ.
  - DROP → stays DROP.
  - IDLE → REQ.
- IF/ID update, in priority order:
  1. `rst`
  2. `redirect_valid`
  3. a load from WAIT or HOLD
  4. `flush` → bubble
  5. `stall` → hold
  6. otherwise → bubble
- `flush` and `stall` together give a bubble. `flush` never alters `pc_q` or the FSM.
- A bubble sets `ifid_valid`=0 and `ifid_instr`=NOP. `ifid_pc` and `ifid_pc_plus4` keep their previous values.

## Timing
- Reset values: `ifid_valid`=0, `ifid_pc`=0, `ifid_pc_plus4`=0, `ifid_instr`=0, `imem_req_valid`=0, `pc_q`=`RESET_PC`.
- `rst` asserted mid-request abandons the request. A response that arrives after reset, while the FSM is in IDLE or REQ, is ignored.
- `imem_req_valid` is first asserted in the cycle after `rst` deasserts (IDLE cycle), i.e. the second cycle after release.
- `imem_req_addr` is stable while `imem_req_valid` is high without `ready`. It changes only on a redirect.
- Latency from handshake at cycle c to `ifid_valid` is (response cycle + 1).
- With zero wait states (`ready`=1, response at c+1), throughput is 1 instruction per 2 cycles.
- Responses in REQ or IDLE are a protocol error and are ignored.

## Structure
- Package `mips_pkg`:
  - `NOP_INSTR` = 32'h0
  - `fetch_state_t` enum
  - `ifid_t` struct {valid, pc, pc_plus4, instr}
- Sub-module `if_id_reg`: holds `ifid_t` and implements the priority list above, with inputs load/load_data/kill/flush/stall. The FSM, PC and hold buffer stay in `fetch_stage`.

## Test plan
- **Reset and straight-line fetch.** `RESET_PC`=0x100, `ready`=1, 1-cycle memory. Expect requests at 0x100, 0x104, 0x108. `ifid_pc` sequence 0x100, 0x104, 0x108, `ifid_valid` alternating, `ifid_pc_plus4`=0x104 with the first instruction.
- **Backpressure.** `ready`=0 for 3 cycles on the 0x104 request. Expect `imem_req_addr` held at 0x104 and no `pc_q` advance.
- **Stall with response in flight.** `stall` rises in WAIT. Response 0x8C220004 goes to HOLD. Expect IF/ID unchanged during the stall, and 0x8C220004 loaded in the first cycle after `stall` falls.
- **Redirect while a request is outstanding.** `redirect_pc`=0x200 in WAIT. Expect the late response dropped and the next request at 0x200. If the redirect coincides with the response instead, expect no DROP and a request at 0x200 the next cycle.
- **Flush vs stall.** `flush`=1 and `stall`=1 with no load. Expect `ifid_valid`=0 and `ifid_instr`=0 next cycle, with `pc_q` unchanged.
- **Reset mid-WAIT.** Assert `rst` while in WAIT, then a stray response arrives. Expect all outputs at reset values and the first request at `RESET_PC`.
